mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Sequential memory-port controller for the 16-bit CPU datapath. It accepts single-cycle fetch/load/store requests from the control unit and drives the external memory handshake (readM/writeM, inputReady/ackOutput). It latches the returned instruction into the instruction register (ir) and returned load data into the memory data register (mdr). ir and mdr feed directly into the datapath's 2:1 and 4:1 selection muxes (write-back source, ALU operand), so both hold their values stable between accesses.

## Interface
Parameters:
- WORD_WIDTH, 16, width of addresses, instructions and data words
- TIMEOUT_CYCLES, 255, wait-cycle limit; only used when MEM_TIMEOUT_EN is defined
- TIMEOUT_W, 8, width of the timeout counter; must satisfy 2^TIMEOUT_W > TIMEOUT_CYCLES

Ports:
- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; forces reset values immediately
- fetch_req  input  1  one-cycle pulse: fetch instruction at pc
- load_req  input  1  one-cycle pulse: read word at data_addr
- store_req  input  1  one-cycle pulse: write store_data to data_addr
- pc  input  WORD_WIDTH  fetch address
- data_addr  input  WORD_WIDTH  load/store address
- store_data  input  WORD_WIDTH  store payload
- busy  output  1  high whenever state != IDLE (decoded from state register)
- instr_valid  output  1  one-cycle pulse: ir updated
- load_done  output  1  one-cycle pulse: mdr updated
- store_done  output  1  one-cycle pulse: store acknowledged
- mem_err  output  1  one-cycle pulse: access aborted by timeout
- ir  output  WORD_WIDTH  instruction register
- mdr  output  WORD_WIDTH  memory data register
- readM  output  1  memory read strobe, registered
- writeM  output  1  memory write strobe, registered
- mem_addr  output  WORD_WIDTH  memory address, registered
- mem_wdata  output  WORD_WIDTH  memory write data, registered
- mem_rdata  input  WORD_WIDTH  memory read data
- inputReady  input  1  memory read data valid
- ackOutput  input  1  memory write accepted

## Operation
- States: IDLE, FETCH, LOAD, STORE.
- Request sampling:
  - Requests are sampled only in IDLE.
  - Priority when several are high on the same edge: store_req > load_req > fetch_req. Lower-priority pulses on that edge are dropped.
  - Requests arriving while busy are dropped; they are not queued.
- IDLE -> FETCH: mem_addr<=pc, readM<=1.
- IDLE -> LOAD: mem_addr<=data_addr, readM<=1.
- IDLE -> STORE: mem_addr<=data_addr, mem_wdata<=store_data, writeM<=1.
- FETCH: on edge with inputReady=1, ir<=mem_rdata, readM<=0, instr_valid<=1, go to IDLE.
- LOAD: on edge with inputReady=1, mdr<=mem_rdata, readM<=0, load_done<=1, go to IDLE.
- STORE: on edge with ackOutput=1, writeM<=0, store_done<=1, go to IDLE.
- Handshake inputs are ignored in IDLE. ackOutput is ignored in FETCH/LOAD; inputReady is ignored in STORE.
- readM and writeM are never high simultaneously.
- ir and mdr change only on their respective completions, or on reset.
- mem_addr and mem_wdata hold their last values in IDLE.
- Reset values: state=IDLE; busy, instr_valid, load_done, store_done, mem_err, readM, writeM = 0; ir, mdr, mem_addr, mem_wdata = 0.
- Reset mid-access: the access is abandoned, strobes drop asynchronously, and no done pulse is produced.

## Timing
- Request pulse sampled at edge N. From edge N: busy=1 and the strobe is high.
- First edge at which the response is sampled is N+1.
- Response high at edge K (K >= N+1):
  - ir/mdr are updated and the done pulse is high for exactly the cycle after K.
  - busy=0 and the strobe is low after edge K.
- Minimum access: 2 edges from request to done pulse. Back-to-back throughput: one access per 2 cycles, because a new request is accepted at the edge after completion at the earliest.
- A request pulsed in the same cycle as a done pulse is accepted.
- Done pulses never last more than one cycle, even if inputReady/ackOutput stays high.

## Configuration
- MEM_TIMEOUT_EN defined:
  - A TIMEOUT_W-bit counter clears on entry to FETCH/LOAD/STORE and increments each cycle without a response.
  - When it reaches TIMEOUT_CYCLES with no response: strobe<=0, mem_err pulses for one cycle, state returns to IDLE, and ir/mdr and the done pulses are unaffected.
  - A response on the same edge as the limit wins; no mem_err is raised.
- MEM_TIMEOUT_EN undefined: no counter is built, the controller waits indefinitely, and mem_err is tied to 0.

## Test plan
- Reset, then fetch_req with pc=0x0010, memory returns 0x6A03 with inputReady one cycle later -> readM=1 and mem_addr=0x0010 for 1 cycle; ir=0x6A03; instr_valid high exactly 1 cycle.
- load_req with data_addr=0x0042, inputReady delayed 5 cycles, mem_rdata=0xBEEF -> busy high for 6 cycles; mdr=0xBEEF; load_done pulses once; ir unchanged.
- store_req with data_addr=0x0080 and store_data=0x1234 -> writeM=1, mem_wdata=0x1234, mem_addr=0x0080 until ackOutput; store_done pulses once.
- fetch_req, load_req and store_req pulsed together -> a store is performed and the other two are dropped; then a fetch_req pulsed while busy -> ignored, no readM afterwards.
- Reset asserted mid-LOAD -> readM=0 immediately, with no clock edge needed; no load_done; mdr=0.
- MEM_TIMEOUT_EN with TIMEOUT_CYCLES=4, fetch with no inputReady -> mem_err pulse after 4 wait cycles, readM=0, ir unchanged, busy=0.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequential memory-port controller for the 16-bit CPU.
// Accepts one-cycle fetch/load/store pulses while idle and runs the external
// readM/writeM handshake. Returned instructions land in ir and load data in
// mdr. Both registers hold their values between accesses because they feed
// the datapath selection muxes directly.
//
// Optional feature macro: MEM_TIMEOUT_EN. When it is defined, an access that
// gets no response within TIMEOUT_CYCLES wait cycles is aborted with a
// mem_err pulse. When it is undefined, the controller waits indefinitely and
// mem_err stays 0.
//
// Ports:
//   clk, reset                      clock, async active-high reset
//   fetch_req/load_req/store_req    request pulses (priority store > load > fetch)
//   pc, data_addr, store_data       request operands
//   busy                            high whenever the controller is not idle
//   instr_valid/load_done/store_done/mem_err   one-cycle completion pulses
//   ir, mdr                         instruction / memory data registers
//   readM, writeM, mem_addr, mem_wdata   registered memory-side outputs
//   mem_rdata, inputReady, ackOutput     memory-side responses
module mem_access_ctrl #(
   parameter int WORD_WIDTH     = 16,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TIMEOUT_W      = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  fetch_req,
   input  logic                  load_req,
   input  logic                  store_req,
   input  logic [WORD_WIDTH-1:0] pc,
   input  logic [WORD_WIDTH-1:0] data_addr,
   input  logic [WORD_WIDTH-1:0] store_data,
   output logic                  busy,
   output logic                  instr_valid,
   output logic                  load_done,
   output logic                  store_done,
   output logic                  mem_err,
   output logic [WORD_WIDTH-1:0] ir,
   output logic [WORD_WIDTH-1:0] mdr,
   output logic                  readM,
   output logic                  writeM,
   output logic [WORD_WIDTH-1:0] mem_addr,
   output logic [WORD_WIDTH-1:0] mem_wdata,
   input  logic [WORD_WIDTH-1:0] mem_rdata,
   input  logic                  inputReady,
   input  logic                  ackOutput
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      LOAD  = 2'd2,
      STORE = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic                  readm_q, readm_d;
   logic                  writem_q, writem_d;
   logic [WORD_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [WORD_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic [WORD_WIDTH-1:0] ir_q, ir_d;
   logic [WORD_WIDTH-1:0] mdr_q, mdr_d;
   logic                  instr_valid_q, instr_valid_d;
   logic                  load_done_q, load_done_d;
   logic                  store_done_q, store_done_d;
   logic                  mem_err_q, mem_err_d;
   logic                  timeout_s;

`ifdef MEM_TIMEOUT_EN
   logic [TIMEOUT_W-1:0]  cnt_q, cnt_d;

   // Abort on the edge where the wait counter would reach the limit.
   assign timeout_s = (cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

   // Wait counter: held at zero while idle so it is clear on entry to an access.
   always_comb begin
      cnt_d = cnt_q;
      if (state_q == IDLE) begin
         cnt_d = {TIMEOUT_W{1'b0}};
      end else begin
         cnt_d = cnt_q + TIMEOUT_W'(1);
      end
   end

   // Wait counter register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= {TIMEOUT_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   assign timeout_s = 1'b0;
`endif

   // Next-state and next-output logic; done pulses default low every cycle.
   always_comb begin
      state_d       = state_q;
      readm_d       = readm_q;
      writem_d      = writem_q;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      ir_d          = ir_q;
      mdr_d         = mdr_q;
      instr_valid_d = 1'b0;
      load_done_d   = 1'b0;
      store_done_d  = 1'b0;
      mem_err_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (store_req) begin
               state_d     = STORE;
               mem_addr_d  = data_addr;
               mem_wdata_d = store_data;
               writem_d    = 1'b1;
               readm_d     = 1'b0;
            end else if (load_req) begin
               state_d    = LOAD;
               mem_addr_d = data_addr;
               readm_d    = 1'b1;
               writem_d   = 1'b0;
            end else if (fetch_req) begin
               state_d    = FETCH;
               mem_addr_d = pc;
               readm_d    = 1'b1;
               writem_d   = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end
         FETCH: begin
            if (inputReady) begin
               ir_d          = mem_rdata;
               readm_d       = 1'b0;
               instr_valid_d = 1'b1;
               state_d       = IDLE;
            end else if (timeout_s) begin
               readm_d   = 1'b0;
               mem_err_d = 1'b1;
               state_d   = IDLE;
            end else begin
               state_d = FETCH;
            end
         end
         LOAD: begin
            if (inputReady) begin
               mdr_d       = mem_rdata;
               readm_d     = 1'b0;
               load_done_d = 1'b1;
               state_d     = IDLE;
            end else if (timeout_s) begin
               readm_d   = 1'b0;
               mem_err_d = 1'b1;
               state_d   = IDLE;
            end else begin
               state_d = LOAD;
            end
         end
         STORE: begin
            if (ackOutput) begin
               writem_d     = 1'b0;
               store_done_d = 1'b1;
               state_d      = IDLE;
            end else if (timeout_s) begin
               writem_d  = 1'b0;
               mem_err_d = 1'b1;
               state_d   = IDLE;
            end else begin
               state_d = STORE;
            end
         end
         default: begin
            state_d  = IDLE;
            readm_d  = 1'b0;
            writem_d = 1'b0;
         end
      endcase
   end

   // Controller state and registered outputs; reset drops strobes at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         readm_q       <= 1'b0;
         writem_q      <= 1'b0;
         mem_addr_q    <= {WORD_WIDTH{1'b0}};
         mem_wdata_q   <= {WORD_WIDTH{1'b0}};
         ir_q          <= {WORD_WIDTH{1'b0}};
         mdr_q         <= {WORD_WIDTH{1'b0}};
         instr_valid_q <= 1'b0;
         load_done_q   <= 1'b0;
         store_done_q  <= 1'b0;
         mem_err_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         readm_q       <= readm_d;
         writem_q      <= writem_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         ir_q          <= ir_d;
         mdr_q         <= mdr_d;
         instr_valid_q <= instr_valid_d;
         load_done_q   <= load_done_d;
         store_done_q  <= store_done_d;
         mem_err_q     <= mem_err_d;
      end
   end

   assign busy        = (state_q != IDLE);
   assign readM       = readm_q;
   assign writeM      = writem_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign ir          = ir_q;
   assign mdr         = mdr_q;
   assign instr_valid = instr_valid_q;
   assign load_done   = load_done_q;
   assign store_done  = store_done_q;
   assign mem_err     = mem_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

   typedef struct packed {
      logic [3:0]  kind;   // {instr_valid, load_done, store_done, mem_err}
      logic [15:0] data;   // expected ir / mdr / mem_wdata / ir
   } exp_t;

`ifdef MEM_TIMEOUT_EN
   localparam int TB_TO = 4;
`else
   localparam int TB_TO = 255;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        fetch_req = 1'b0, load_req = 1'b0, store_req = 1'b0;
   logic [15:0] pc = 16'h0000, data_addr = 16'h0000, store_data = 16'h0000;
   logic        busy, instr_valid, load_done, store_done, mem_err;
   logic [15:0] ir, mdr, mem_addr, mem_wdata;
   logic        readM, writeM;
   logic [15:0] mem_rdata = 16'h0000;
   logic        inputReady = 1'b0, ackOutput = 1'b0;

   int   total = 0;
   int   bad = 0;
   exp_t sb[$];
   exp_t mon_e;
   logic [3:0] mon_p;

   mem_access_ctrl #(.WORD_WIDTH(16), .TIMEOUT_CYCLES(TB_TO), .TIMEOUT_W(8)) dut (
      .clk(clk), .reset(reset),
      .fetch_req(fetch_req), .load_req(load_req), .store_req(store_req),
      .pc(pc), .data_addr(data_addr), .store_data(store_data),
      .busy(busy), .instr_valid(instr_valid), .load_done(load_done),
      .store_done(store_done), .mem_err(mem_err),
      .ir(ir), .mdr(mdr), .readM(readM), .writeM(writeM),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .inputReady(inputReady), .ackOutput(ackOutput)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: pops the scoreboard whenever a completion pulse is visible.
   always @(negedge clk) begin
      if (!reset) begin
         mon_p = {instr_valid, load_done, store_done, mem_err};
         if (mon_p != 4'b0000) begin
            if (sb.size() == 0) begin
               chk("spurious_done", {28'd0, mon_p}, 32'd0);
            end else begin
               mon_e = sb.pop_front();
               chk("done_kind", {28'd0, mon_p}, {28'd0, mon_e.kind});
               case (mon_e.kind)
                  4'b1000: chk("ir_value", {16'd0, ir}, {16'd0, mon_e.data});
                  4'b0100: chk("mdr_value", {16'd0, mdr}, {16'd0, mon_e.data});
                  4'b0010: chk("store_wdata", {16'd0, mem_wdata}, {16'd0, mon_e.data});
                  default: chk("ir_after_err", {16'd0, ir}, {16'd0, mon_e.data});
               endcase
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [3:0] k, input logic [15:0] d);
      exp_t e;
      e.kind = k;
      e.data = d;
      sb.push_back(e);
   endtask

   task automatic issue(input logic f, input logic l, input logic s);
      fetch_req = f; load_req = l; store_req = s;
      tick();
      fetch_req = 1'b0; load_req = 1'b0; store_req = 1'b0;
   endtask

   // Memory responder: waits `delay` edges (with the other handshake and junk
   // read data asserted as noise), then responds on the next edge.
   task automatic respond(input logic is_store, input int delay, input logic [15:0] rdata,
                          input logic poke, input string nm);
      int bc = 0;
      for (int i = 0; i < delay; i++) begin
         if (busy) bc++;
         chk({nm, "_strobe_hold"}, {31'd0, (is_store ? writeM : readM)}, 32'd1);
         inputReady = is_store;
         ackOutput  = !is_store;
         mem_rdata  = 16'hDEAD;
         if (poke && i == 0) begin
            fetch_req = 1'b1;
            pc        = 16'h0777;
         end
         tick();
         fetch_req = 1'b0;
      end
      if (busy) bc++;
      inputReady = !is_store;
      ackOutput  = is_store;
      mem_rdata  = rdata;
      tick();
      inputReady = 1'b0;
      ackOutput  = 1'b0;
      mem_rdata  = 16'h0000;
      chk({nm, "_busy_cycles"}, bc, delay + 1);
      chk({nm, "_busy_after"}, {31'd0, busy}, 32'd0);
      chk({nm, "_strobes_after"}, {30'd0, readM, writeM}, 32'd0);
   endtask

   initial begin
      // Reset values
      tick();
      tick();
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_strobes", {30'd0, readM, writeM}, 32'd0);
      chk("rst_pulses", {28'd0, instr_valid, load_done, store_done, mem_err}, 32'd0);
      chk("rst_ir_mdr", {ir, mdr}, 32'd0);
      chk("rst_addr_wdata", {mem_addr, mem_wdata}, 32'd0);
      reset = 1'b0;
      tick();

      // Fetch with immediate response
      pc = 16'h0010;
      push(4'b1000, 16'h6A03);
      issue(1'b1, 1'b0, 1'b0);
      chk("fetch_busy", {31'd0, busy}, 32'd1);
      chk("fetch_strobes", {30'd0, readM, writeM}, 32'd2);
      chk("fetch_addr", {16'd0, mem_addr}, 32'h0010);
      respond(1'b0, 0, 16'h6A03, 1'b0, "fetch");
      chk("fetch_ir", {16'd0, ir}, 32'h6A03);

      // inputReady held high while idle must be ignored
      inputReady = 1'b1;
      mem_rdata  = 16'hFFFF;
      tick();
      tick();
      inputReady = 1'b0;
      chk("idle_ready_busy", {31'd0, busy}, 32'd0);
      chk("idle_ready_ir", {16'd0, ir}, 32'h6A03);

      // Load with 5-cycle response delay
      data_addr = 16'h0042;
      push(4'b0100, 16'hBEEF);
      issue(1'b0, 1'b1, 1'b0);
      chk("load_strobes", {30'd0, readM, writeM}, 32'd2);
      chk("load_addr", {16'd0, mem_addr}, 32'h0042);
      respond(1'b0, 5, 16'hBEEF, 1'b0, "load");
      chk("load_mdr", {16'd0, mdr}, 32'hBEEF);
      chk("load_ir_kept", {16'd0, ir}, 32'h6A03);

      // Request in the same cycle as the load_done pulse is accepted
      pc = 16'h0011;
      push(4'b1000, 16'h1357);
      issue(1'b1, 1'b0, 1'b0);
      chk("b2b_busy", {31'd0, busy}, 32'd1);
      chk("b2b_addr", {16'd0, mem_addr}, 32'h0011);
      respond(1'b0, 1, 16'h1357, 1'b0, "b2b");
      chk("b2b_mdr_kept", {16'd0, mdr}, 32'hBEEF);

      // Store
      data_addr  = 16'h0080;
      store_data = 16'h1234;
      push(4'b0010, 16'h1234);
      issue(1'b0, 1'b0, 1'b1);
      chk("store_strobes", {30'd0, readM, writeM}, 32'd1);
      chk("store_addr", {16'd0, mem_addr}, 32'h0080);
      chk("store_wdata_out", {16'd0, mem_wdata}, 32'h1234);
      respond(1'b1, 3, 16'h0000, 1'b0, "store");
      chk("store_hold_addr", {mem_addr, mem_wdata}, 32'h0080_1234);

      // All three requests together: store wins, fetch while busy dropped
      pc         = 16'h0020;
      data_addr  = 16'h0090;
      store_data = 16'h5555;
      push(4'b0010, 16'h5555);
      issue(1'b1, 1'b1, 1'b1);
      chk("prio_strobes", {30'd0, readM, writeM}, 32'd1);
      chk("prio_addr", {16'd0, mem_addr}, 32'h0090);
      respond(1'b1, 2, 16'h0000, 1'b1, "prio");
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("prio_no_readM", {30'd0, readM, busy}, 32'd0);
      end
      chk("prio_ir_kept", {16'd0, ir}, 32'h1357);
      chk("prio_mdr_kept", {16'd0, mdr}, 32'hBEEF);

`ifdef MEM_TIMEOUT_EN
      // Fetch with no response aborts after TB_TO wait cycles
      pc = 16'h0030;
      push(4'b0001, 16'h1357);
      issue(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < TB_TO - 1; i++) begin
         tick();
         chk("to_busy_wait", {31'd0, busy}, 32'd1);
      end
      tick();
      chk("to_busy_after", {30'd0, busy, readM}, 32'd0);
      chk("to_ir_kept", {16'd0, ir}, 32'h1357);
      tick();
`endif

      // Reset mid-load: strobe drops without a clock edge, no load_done
      data_addr = 16'h0044;
      issue(1'b0, 1'b1, 1'b0);
      tick();
      chk("midrst_readM_before", {31'd0, readM}, 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("midrst_readM", {31'd0, readM}, 32'd0);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_mdr", {16'd0, mdr}, 32'd0);
      tick();
      reset = 1'b0;
      inputReady = 1'b1;
      mem_rdata  = 16'hABCD;
      tick();
      tick();
      inputReady = 1'b0;
      tick();
      chk("postrst_mdr", {16'd0, mdr}, 32'd0);
      chk("postrst_busy", {31'd0, busy}, 32'd0);

      tick();
      chk("sb_drain", sb.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
